dmem_controller: RTL

Sequences data-memory accesses for the MEM stage of the MIPS-III pipeline. It takes MEM-stage control (MemRead/MemWrite/MemHalf/MemByte/MemSignExtend/LLSC) plus address and store data, and drives a single-outstanding req/ack data bus with byte enables. It aligns and sign-extends load data and implements the LL/SC link register. It produces StallController, the D-Memory stall request, which holds the pipeline until the access completes.

---
 rtl/dmem_pkg.sv | 74 +++++++
 rtl/dmem_load_align.sv | 17 +
 rtl/dmem_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the MEM-stage data memory controller.
// Lane numbering follows the bus: lane i occupies bits 8i+7:8i.
package dmem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    // Everything the bus needs, captured when the access is launched.
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        size_e       size;
        logic        sign;
        logic        ll;
        logic        sc;
    } req_t;

    function automatic logic [1:0] byte_lane(input logic big_endian, input logic [1:0] a);
        return big_endian ? ~a : a;
    endfunction

    // 1 when the addressed halfword sits on bits 31:16.
    function automatic logic half_upper(input logic big_endian, input logic [1:0] a);
        return big_endian ? ~a[1] : a[1];
    endfunction

    function automatic logic [3:0] lane_be(input logic big_endian, input size_e size,
                                           input logic [1:0] a);
        logic [3:0] be;
        case (size)
            BYTE:    be = 4'b0001 << byte_lane(big_endian, a);
            HALF:    be = half_upper(big_endian, a) ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_replicate(input size_e size, input logic [31:0] wd);
        logic [31:0] r;
        case (size)
            BYTE:    r = {4{wd[7:0]}};
            HALF:    r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_align(input logic big_endian, input size_e size,
                                               input logic sign, input logic [1:0] a,
                                               input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[{byte_lane(big_endian, a), 3'b000} +: 8];
        h = rdata[{half_upper(big_endian, a), 4'b0000} +: 16];
        case (size)
            BYTE:    r = {{24{sign & b[7]}}, b};
            HALF:    r = {{16{sign & h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load formatter: picks the addressed lane out of the bus word
// and zero- or sign-extends it to 32 bits.
module dmem_load_align
    import dmem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  size_e       size_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    assign data_o = load_align(BIG_ENDIAN, size_i, sign_i, addr_lo_i, rdata_i);

endmodule

// File: rtl/dmem_controller.sv
// MEM-stage data memory sequencer: single-outstanding req/ack bus, load
// alignment, LL/SC link register and the D-memory stall request.
module dmem_controller
    import dmem_pkg::*;
#(
    parameter bit BIG_ENDIAN        = 1'b1,
    parameter bit STORE_BREAKS_LINK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemHalf,
    input  logic        MemByte,
    input  logic        MemSignExtend,
    input  logic        LLSC,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic        StallController,
    output logic [31:0] MemReadData,
    output logic        AddrErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic        done_q, done_d;
    logic        kill_q, kill_d;
    logic        link_valid_q, link_valid_d;
    logic [29:0] link_addr_q, link_addr_d;
    logic [31:0] rdata_q, rdata_d;

    size_e       size_in;
    logic        op, misaligned, link_match, sc_fail, advance, set_done;
    logic [31:0] load_data;

    always_comb begin
        size_in = WORD;
        if (MemByte)      size_in = BYTE;
        else if (MemHalf) size_in = HALF;
    end

    assign op         = (MemRead | MemWrite) & ~done_q;
    assign misaligned = ((size_in == HALF) & Addr[0]) | ((size_in == WORD) & (Addr[1:0] != 2'b00));
    assign link_match = link_valid_q & (link_addr_q == Addr[31:2]);
    assign sc_fail    = MemWrite & LLSC & ~link_match;

    assign StallController = (op & ~Flush & ~misaligned & ~sc_fail) | (state_q == REQ);
    assign AddrErr         = (state_q == IDLE) & op & ~Flush & misaligned;
    // The instruction leaves MEM only on an edge where nothing stalls it.
    assign advance         = ~Stall & ~StallController;

    assign MemReadData = rdata_q;
    assign bus_req     = (state_q == REQ);
    assign bus_we      = bus_req & req_q.we;
    assign bus_addr    = bus_req ? {req_q.addr[31:2], 2'b00} : 32'h0;
    assign bus_be      = bus_req ? req_q.be : 4'h0;
    assign bus_wdata   = bus_req ? req_q.wdata : 32'h0;

    dmem_load_align #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_load_align (
        .rdata_i  (bus_rdata),
        .addr_lo_i(req_q.addr[1:0]),
        .size_i   (req_q.size),
        .sign_i   (req_q.sign),
        .data_o   (load_data)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        kill_d       = kill_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        rdata_d      = rdata_q;
        set_done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (Flush) begin
                    link_valid_d = 1'b0;
                end else if (op) begin
                    if (misaligned) begin
                        set_done = 1'b1;
                    end else if (sc_fail) begin
                        rdata_d  = 32'h0;
                        set_done = 1'b1;
                    end else begin
                        state_d     = REQ;
                        req_d.addr  = Addr;
                        req_d.be    = lane_be(BIG_ENDIAN, size_in, Addr[1:0]);
                        req_d.wdata = MemWrite ? store_replicate(size_in, WriteData) : 32'h0;
                        req_d.we    = MemWrite;
                        req_d.size  = size_in;
                        req_d.sign  = MemSignExtend;
                        req_d.ll    = MemRead & ~MemWrite & LLSC;
                        req_d.sc    = MemWrite & LLSC;
                    end
                end
            end
            REQ: begin
                if (bus_ack) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                    // A flushed access still has to finish on the bus; its result is dropped.
                    if (!(kill_q | Flush)) begin
                        set_done = 1'b1;
                        if (req_q.sc) begin
                            rdata_d      = 32'd1;
                            link_valid_d = 1'b0;
                        end else if (!req_q.we) begin
                            rdata_d = load_data;
                        end
                        if (req_q.ll) begin
                            link_valid_d = 1'b1;
                            link_addr_d  = req_q.addr[31:2];
                        end
                        if (STORE_BREAKS_LINK && req_q.we && !req_q.sc && link_valid_q &&
                            (link_addr_q == req_q.addr[31:2])) begin
                            link_valid_d = 1'b0;
                        end
                    end
                end else if (Flush) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        done_d = done_q;
        if (advance)       done_d = 1'b0;
        else if (set_done) done_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_q        <= '0;
            done_q       <= 1'b0;
            kill_q       <= 1'b0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            done_q       <= done_d;
            kill_q       <= kill_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            rdata_q      <= rdata_d;
        end
    end

endmodule
